// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/point/over sequencing plus paddle, ball and score state.
// Define PONG_P2_AI_EN to make the player 2 paddle follow the ball automatically.
module pong_game_ctrl #(
    parameter int GRID_W        = 40,
    parameter int GRID_H        = 30,
    parameter int P1_PADDLE_X   = 0,
    parameter int P2_PADDLE_X   = 39,
    parameter int PADDLE_HEIGHT = 6,
    parameter int BALL_DIV      = 4,
    parameter int PADDLE_DIV    = 2,
    parameter int SERVE_DELAY   = 30,
    parameter int WIN_SCORE     = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    output logic [5:0] p1_paddle_y,
    output logic [5:0] p2_paddle_y,
    output logic [5:0] ball_x,
    output logic [5:0] ball_y,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       playing,
    output logic       game_over
);

    localparam int SW = $clog2(SERVE_DELAY + 1);
    localparam int BW = $clog2(BALL_DIV + 1);
    localparam int PW = $clog2(PADDLE_DIV + 1);

    localparam logic [5:0] PY0         = 6'((GRID_H - 1 - PADDLE_HEIGHT) / 2);
    localparam logic [5:0] PY_MAX      = 6'(GRID_H - 1 - PADDLE_HEIGHT);
    localparam logic [5:0] Y_MAX       = 6'(GRID_H - 1);
    localparam logic [5:0] CX          = 6'(GRID_W / 2);
    localparam logic [5:0] CY          = 6'(GRID_H / 2);
    localparam logic [5:0] PH          = 6'(PADDLE_HEIGHT);
    localparam logic [5:0] P1_X        = 6'(P1_PADDLE_X);
    localparam logic [5:0] P2_X        = 6'(P2_PADDLE_X);
    localparam logic [5:0] P1_HIT_X    = 6'(P1_PADDLE_X + 1);
    localparam logic [5:0] P2_HIT_X    = 6'(P2_PADDLE_X - 1);
    localparam logic [5:0] P1_BOUNCE_X = 6'(P1_PADDLE_X + 2);
    localparam logic [5:0] P2_BOUNCE_X = 6'(P2_PADDLE_X - 2);
    localparam logic [3:0] WIN         = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        POINT,
        OVER
    } state_t;

    state_t        state;
    logic [SW-1:0] serve_cnt;
    logic [BW-1:0] ball_div;
    logic [PW-1:0] paddle_div;
    logic          dx_neg;
    logic          dy_neg;

    logic          p2_move_up;
    logic          p2_move_down;
    logic          dy_next;
    logic [5:0]    ball_y_next;
    logic          p1_hit;
    logic          p2_hit;

`ifdef PONG_P2_AI_EN
    logic [5:0] p2_center;
    logic       ai_unused_buttons;
    assign p2_center         = p2_paddle_y + 6'(PADDLE_HEIGHT / 2);
    assign p2_move_up        = ball_y < p2_center;
    assign p2_move_down      = ball_y > p2_center;
    assign ai_unused_buttons = p2_up ^ p2_down;
`else
    assign p2_move_up   = p2_up;
    assign p2_move_down = p2_down;
`endif

    function automatic logic [5:0] paddle_step(input logic [5:0] y, input logic up,
                                               input logic down);
        logic [5:0] r;
        r = y;
        if (up && !down && y != 6'd0)
            r = y - 6'd1;
        else if (down && !up && y < PY_MAX)
            r = y + 6'd1;
        return r;
    endfunction

    // Collision tests use the paddle rows held before this tick's paddle step.
    always_comb begin
        dy_next     = dy_neg ^ ((ball_y == 6'd0 && dy_neg) || (ball_y == Y_MAX && !dy_neg));
        ball_y_next = dy_next ? ball_y - 6'd1 : ball_y + 6'd1;
        p1_hit      = (p1_paddle_y <= ball_y) && (ball_y <= p1_paddle_y + PH);
        p2_hit      = (p2_paddle_y <= ball_y) && (ball_y <= p2_paddle_y + PH);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            serve_cnt   <= '0;
            ball_div    <= '0;
            paddle_div  <= '0;
            p1_paddle_y <= PY0;
            p2_paddle_y <= PY0;
            ball_x      <= CX;
            ball_y      <= CY;
            dx_neg      <= 1'b0;
            dy_neg      <= 1'b0;
            p1_score    <= 4'd0;
            p2_score    <= 4'd0;
            playing     <= 1'b0;
            game_over   <= 1'b0;
        end else if (frame_tick) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SERVE;
                        serve_cnt <= '0;
                    end
                end
                SERVE: begin
                    if (serve_cnt == SW'(SERVE_DELAY - 1)) begin
                        state    <= PLAY;
                        playing  <= 1'b1;
                        ball_div <= '0;
                    end else begin
                        serve_cnt <= serve_cnt + 1'b1;
                    end
                end
                PLAY: begin
                    if (paddle_div == PW'(PADDLE_DIV - 1)) begin
                        paddle_div  <= '0;
                        p1_paddle_y <= paddle_step(p1_paddle_y, p1_up, p1_down);
                        p2_paddle_y <= paddle_step(p2_paddle_y, p2_move_up, p2_move_down);
                    end else begin
                        paddle_div <= paddle_div + 1'b1;
                    end

                    if (ball_div == BW'(BALL_DIV - 1)) begin
                        ball_div <= '0;
                        dy_neg   <= dy_next;
                        ball_y   <= ball_y_next;
                        if (dx_neg && ball_x == P1_HIT_X) begin
                            if (p1_hit) begin
                                dx_neg <= 1'b0;
                                ball_x <= P1_BOUNCE_X;
                            end else begin
                                ball_x  <= P1_X;
                                state   <= POINT;
                                playing <= 1'b0;
                                if (p2_score < WIN)
                                    p2_score <= p2_score + 4'd1;
                            end
                        end else if (!dx_neg && ball_x == P2_HIT_X) begin
                            if (p2_hit) begin
                                dx_neg <= 1'b1;
                                ball_x <= P2_BOUNCE_X;
                            end else begin
                                ball_x  <= P2_X;
                                state   <= POINT;
                                playing <= 1'b0;
                                if (p1_score < WIN)
                                    p1_score <= p1_score + 4'd1;
                            end
                        end else begin
                            ball_x <= dx_neg ? ball_x - 6'd1 : ball_x + 6'd1;
                        end
                    end else begin
                        ball_div <= ball_div + 1'b1;
                    end
                end
                POINT: begin
                    if (p1_score == WIN || p2_score == WIN) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                    end else begin
                        // The ball sits on the loser's paddle column, so serve back toward it.
                        state     <= SERVE;
                        serve_cnt <= '0;
                        dx_neg    <= (ball_x == P1_X);
                        ball_x    <= CX;
                        ball_y    <= CY;
                    end
                end
                OVER: begin
                    if (start) begin
                        state       <= SERVE;
                        serve_cnt   <= '0;
                        game_over   <= 1'b0;
                        p1_score    <= 4'd0;
                        p2_score    <= 4'd0;
                        p1_paddle_y <= PY0;
                        p2_paddle_y <= PY0;
                        ball_x      <= CX;
                        ball_y      <= CY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: a behavioural game model predicts every output on
// every clock, expectations are queued when stimulus is driven and popped after the edge.
module tb_pong_game_ctrl;

    localparam int S_IDLE  = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY  = 2;
    localparam int S_POINT = 3;
    localparam int S_OVER  = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic       p1_up, p1_down, p2_up, p2_down;
    logic [5:0] p1_paddle_y, p2_paddle_y, ball_x, ball_y;
    logic [3:0] p1_score, p2_score;
    logic       playing, game_over;

    int vectors     = 0;
    int miscompares = 0;

    logic [33:0] exp_q[$];
    logic [33:0] dut_vec;

    int m_state, m_p1, m_p2, m_bx, m_by, m_dx, m_dy, m_s1, m_s2;
    int m_scnt, m_bdiv, m_pdiv, m_playing, m_over;

    pong_game_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .start       (start),
        .p1_up       (p1_up),
        .p1_down     (p1_down),
        .p2_up       (p2_up),
        .p2_down     (p2_down),
        .p1_paddle_y (p1_paddle_y),
        .p2_paddle_y (p2_paddle_y),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .p1_score    (p1_score),
        .p2_score    (p2_score),
        .playing     (playing),
        .game_over   (game_over)
    );

    always #5 clock = ~clock;

    assign dut_vec = {p1_paddle_y, p2_paddle_y, ball_x, ball_y, p1_score, p2_score,
                      playing, game_over};

    function automatic logic [33:0] model_vec();
        return {6'(m_p1), 6'(m_p2), 6'(m_bx), 6'(m_by), 4'(m_s1), 4'(m_s2),
                1'(m_playing), 1'(m_over)};
    endfunction

    function automatic int move_paddle(input int y, input logic up, input logic dn);
        int r;
        r = y;
        if (up && !dn) r = y - 1;
        if (dn && !up) r = y + 1;
        if (r < 0) r = 0;
        if (r > 23) r = 23;
        return r;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_p1 = 11; m_p2 = 11; m_bx = 20; m_by = 15;
        m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0;
        m_scnt = 0; m_bdiv = 0; m_pdiv = 0; m_playing = 0; m_over = 0;
    endtask

    task automatic model_tick(input logic st, input logic [3:0] btn);
        int op1, op2;
        op1 = m_p1;
        op2 = m_p2;
        case (m_state)
            S_IDLE: if (st) begin m_state = S_SERVE; m_scnt = 0; end
            S_SERVE: begin
                m_scnt++;
                if (m_scnt == 30) begin m_state = S_PLAY; m_playing = 1; m_bdiv = 0; end
            end
            S_PLAY: begin
                m_pdiv++;
                if (m_pdiv == 2) begin
                    m_pdiv = 0;
                    m_p1 = move_paddle(m_p1, btn[3], btn[2]);
                    m_p2 = move_paddle(m_p2, btn[1], btn[0]);
                end
                m_bdiv++;
                if (m_bdiv == 4) begin
                    m_bdiv = 0;
                    if ((m_by == 0 && m_dy < 0) || (m_by == 29 && m_dy > 0)) m_dy = -m_dy;
                    if (m_dx < 0 && m_bx == 1) begin
                        if (m_by >= op1 && m_by <= op1 + 6) begin
                            m_dx = 1; m_bx = 2;
                        end else begin
                            m_bx = 0; m_state = S_POINT; m_playing = 0;
                            m_s2 = (m_s2 + 1 > 7) ? 7 : m_s2 + 1;
                        end
                    end else if (m_dx > 0 && m_bx == 38) begin
                        if (m_by >= op2 && m_by <= op2 + 6) begin
                            m_dx = -1; m_bx = 37;
                        end else begin
                            m_bx = 39; m_state = S_POINT; m_playing = 0;
                            m_s1 = (m_s1 + 1 > 7) ? 7 : m_s1 + 1;
                        end
                    end else begin
                        m_bx = m_bx + m_dx;
                    end
                    m_by = m_by + m_dy;
                end
            end
            S_POINT: begin
                if (m_s1 == 7 || m_s2 == 7) begin
                    m_state = S_OVER; m_over = 1;
                end else begin
                    m_dx = (m_bx == 0) ? -1 : 1;
                    m_bx = 20; m_by = 15; m_scnt = 0; m_state = S_SERVE;
                end
            end
            default: begin
                if (st) begin
                    m_s1 = 0; m_s2 = 0; m_p1 = 11; m_p2 = 11;
                    m_bx = 20; m_by = 15; m_scnt = 0; m_over = 0; m_state = S_SERVE;
                end
            end
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [33:0] observed,
                               input logic [33:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h expected %h (p1y,p2y,bx,by,s1,s2,play,over)",
                     tag, $time, observed, expected);
        end
    endtask

    // One clock: drive inputs, queue the model's prediction, compare just after the edge.
    task automatic applyStimulus(input logic tick, input logic st, input logic [3:0] btn,
                                 input string tag);
        frame_tick = tick;
        start      = st;
        {p1_up, p1_down, p2_up, p2_down} = btn;
        if (tick) model_tick(st, btn);
        exp_q.push_back(model_vec());
        @(posedge clock);
        #1;
        checkOutput(tag, dut_vec, exp_q.pop_front());
        frame_tick = 1'b0;
    endtask

    // A frame tick followed by an idle cycle carrying junk inputs that must be ignored.
    task automatic frame(input logic st, input logic [3:0] btn, input string tag);
        applyStimulus(1'b1, st, btn, tag);
        applyStimulus(1'b0, 1'($urandom), 4'($urandom), "idle_cycle");
    endtask

    // Player 1 mostly tracks the ball; player 2 mashes buttons at random.
    task automatic play_frame(input string tag);
        logic [1:0] p1b;
        if ($urandom_range(3) != 0) begin
            if (m_by < m_p1 + 3)      p1b = 2'b10;
            else if (m_by > m_p1 + 3) p1b = 2'b01;
            else                      p1b = 2'b00;
        end else begin
            p1b = 2'($urandom);
        end
        frame(1'b0, {p1b, 2'($urandom)}, tag);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        reset = 1'b1;
        frame_tick = 1'b0;
        start = 1'b0;
        {p1_up, p1_down, p2_up, p2_down} = 4'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_values", dut_vec, model_vec());
        reset = 1'b0;

        for (int i = 0; i < 5; i++) frame(1'b0, 4'($urandom), "idle_no_start");

        frame(1'b1, 4'b0000, "start_tick");
        for (int i = 0; i < 34; i++) frame(1'b0, 4'($urandom), "serve_then_first_step");

        guard = 0;
        while (!m_over && guard < 8000) begin
            play_frame("play");
            guard++;
        end
        checkOutput("over_reached", {33'b0, game_over}, 34'd1);

        for (int i = 0; i < 10; i++) frame(1'b0, 4'($urandom), "over_frozen");
        frame(1'b1, 4'b0000, "restart");
        for (int i = 0; i < 300; i++) play_frame("second_game");

        // Asynchronous reset in the middle of a frame must take effect before any edge.
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        checkOutput("async_reset", dut_vec, model_vec());
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("reset_held", dut_vec, model_vec());
        for (int i = 0; i < 3; i++) frame(1'b0, 4'($urandom), "post_reset_idle");
        frame(1'b1, 4'b0000, "post_reset_start");
        for (int i = 0; i < 60; i++) play_frame("post_reset_play");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game controller for the Pong datapath: sequences serve/play/score/game-over and owns all moving-object state (paddle rows, ball position and direction, scores). Advances once per video frame on `frame_tick` and drives the paddle/ball coordinates that the pixel draw stage compares against the scan counters. All coordinates are grid cells, not pixels.

## Interface
Parameters:
- `GRID_W`, 40: grid columns; valid columns are 0..39.
- `GRID_H`, 30: grid rows; valid rows are 0..29.
- `P1_PADDLE_X`, 0: player 1 paddle column.
- `P2_PADDLE_X`, 39: player 2 paddle column.
- `PADDLE_HEIGHT`, 6: a paddle occupies rows `y`..`y+PADDLE_HEIGHT` inclusive (7 rows).
- `BALL_DIV`, 4: frames per ball step.
- `PADDLE_DIV`, 2: frames per paddle step.
- `SERVE_DELAY`, 30: frames the ball is held before each serve.
- `WIN_SCORE`, 7: score that ends the game.

Ports (the clock is `clock`; reset is `reset`, asynchronous and active-high):
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse per frame.
- `start` in 1: level; sampled only on `frame_tick`.
- `p1_up`, `p1_down`, `p2_up`, `p2_down` in 1 each: level button inputs, already debounced.
- `p1_paddle_y`, `p2_paddle_y` out 6: top row of each paddle.
- `ball_x`, `ball_y` out 6: ball cell.
- `p1_score`, `p2_score` out 4: current scores.
- `playing` out 1: high in PLAY state.
- `game_over` out 1: high in OVER state.

## Operation
- States: IDLE, SERVE, PLAY, POINT, OVER.
- Reset values:
  - State is IDLE.
  - Both paddles at `PY0 = (GRID_H-1-PADDLE_HEIGHT)/2` = 11.
  - Ball at (`GRID_W/2`, `GRID_H/2`) = (20, 15).
  - `dx` = +1, `dy` = +1.
  - Scores are 0; `playing` and `game_over` are 0.
  - Frame divider counters are 0.
- IDLE: on `frame_tick` with `start` high, go to SERVE and clear the serve counter.
- SERVE: ball held at center and paddles frozen. Count `SERVE_DELAY` frame ticks, then go to PLAY; clear the ball divider.
- PLAY, on each `frame_tick`:
  - Paddle divider: every `PADDLE_DIV`-th tick, each paddle moves by 1.
    - `up` decrements the row; `down` increments it.
    - Both buttons high, or neither: no move.
    - Row is clamped to 0..`GRID_H-1-PADDLE_HEIGHT` (0..23).
  - Ball divider: every `BALL_DIV`-th tick the ball steps once. All collision checks use the paddle rows registered before this tick's paddle update.
  - Vertical step:
    - If `ball_y`=0 with `dy`=-1, or `ball_y`=`GRID_H-1` with `dy`=+1, negate `dy` first.
    - Then `ball_y += dy`.
  - Horizontal step, left side (`dx`=-1, `ball_x`=`P1_PADDLE_X+1`):
    - Hit when `p1_paddle_y` ≤ `ball_y` ≤ `p1_paddle_y+PADDLE_HEIGHT`, using the pre-step `ball_y`. On a hit, `dx` becomes +1 and `ball_x` becomes `P1_PADDLE_X+2`.
    - On a miss, `ball_x` becomes `P1_PADDLE_X`, `p2_score` increments, and the state goes to POINT.
  - Horizontal step, right side: mirror of the left side using `P2_PADDLE_X-1`, the p2 paddle and `p1_score`.
  - Otherwise, `ball_x += dx`.
- POINT: lasts one frame tick.
  - If either score equals `WIN_SCORE`, go to OVER.
  - Otherwise go to SERVE with the ball recentered and `dx` pointing toward the player who lost the point. `dy` is kept.
- OVER: all state frozen. On `frame_tick` with `start` high:
  - Scores cleared, paddles set to `PY0`, ball recentered.
  - Go to SERVE.
- Scores saturate at `WIN_SCORE`. The 4-bit score width is sufficient for `WIN_SCORE` ≤ 15.

## Timing
- All outputs are registered and update on the `clock` edge on which `frame_tick` is sampled high. Latency is 1 clock.
- Outputs are stable between ticks. Cycles without `frame_tick` never change state.
- Asserting `reset` mid-frame or mid-game immediately forces all reset values; no partial update completes.
- Button and `start` inputs are only evaluated in `frame_tick` cycles.

## Configuration
- `PONG_P2_AI_EN` defined: the player 2 paddle is automatic.
  - `p2_up`/`p2_down` are ignored.
  - On each paddle step, the paddle moves toward the ball. Let `c = p2_paddle_y + PADDLE_HEIGHT/2`.
  - If `ball_y < c`, move up; if `ball_y > c`, move down; equal means no move. Same clamp as manual play.
- `PONG_P2_AI_EN` undefined: player 2 is driven by `p2_up`/`p2_down` exactly like player 1.

## Test plan
- Reset, then 5 ticks with `start`=0 -> state IDLE, ball (20,15), paddles 11/11, scores 0/0.
- `start`=1 for one tick -> `playing` rises after exactly 30 further ticks; the first ball step occurs 4 ticks later -> ball (21,16).
- Ball at (10,29) with `dy`=+1 on a ball step -> `ball_y`=28, `dy`=-1; with `p1_up` and `p1_down` both high, `p1_paddle_y` is unchanged.
- `dx`=-1, `ball_x`=1, `ball_y`=14, `p1_paddle_y`=8 -> `ball_x`=2, `dx`=+1; repeat with `p1_paddle_y`=15 -> `ball_x`=0, `p2_score`=1, then SERVE with `dx`=-1.
- `p2_score`=6, then a p1 miss -> `p2_score`=7, `game_over`=1, all outputs frozen for 10 ticks; `start` -> scores 0/0, SERVE.
- With `PONG_P2_AI_EN`: `ball_y`=25, `p2_paddle_y`=0, buttons idle -> paddle reaches 22 and holds.
